// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst write arbiter in front of a single-clock FIFO
//
// Shares one FIFO write port among NUM_REQ valid/ready producers. In IDLE the
// arbiter picks the next valid producer after the previous winner, then locks
// onto it for a burst of up to MAX_BURST beats. Accepted beats are forwarded
// combinationally to the FIFO write side; FIFO full stalls the granted producer.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req_valid     per-producer beat valid
//   req_data      producer i data in bits [i*DATA_W +: DATA_W]
//   req_last      per-producer end-of-packet marker
//   req_ready     per-producer beat accepted (only granted producer, only when not full)
//   fifo_full     FIFO full flag (registered inside the FIFO)
//   fifo_wr_en    FIFO write strobe
//   fifo_wr_data  FIFO write data, zero when fifo_wr_en is low
//   grant_id      current or most recent owner index
//   busy          high while a burst is in progress

module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4,
    localparam int GID_W    = $clog2(NUM_REQ),
    localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wr_data,
    output logic [GID_W-1:0]          grant_id,
    output logic                      busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [GID_W-1:0]   last_winner;
    logic [CNT_W-1:0]   beat_cnt;

    logic               any_valid;
    logic               found;
    logic [GID_W-1:0]   winner;
    logic [GID_W:0]     cand;

    logic               g_valid;
    logic               g_last;
    logic [DATA_W-1:0]  g_data;
    logic               accept;
    logic [CNT_W-1:0]   beat_cnt_inc;
    logic               hit_max;
    logic               burst_end;

    // Round-robin search: first valid index strictly after last_winner,
    // wrapping modulo NUM_REQ. The extra bit in cand keeps the sum from
    // overflowing before the wrap subtraction for non-power-of-two NUM_REQ.
    always_comb begin
        any_valid = |req_valid;
        found     = 1'b0;
        winner    = '0;
        cand      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = {1'b0, last_winner} + (GID_W+1)'(off);
            if (cand >= (GID_W+1)'(NUM_REQ)) begin
                cand = cand - (GID_W+1)'(NUM_REQ);
            end
            if (!found && req_valid[cand[GID_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[GID_W-1:0];
            end
        end
    end

    // Granted producer's stream signals.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GID_W'(i) == grant_id) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign accept       = (state == BURST) && g_valid && !fifo_full;
    assign beat_cnt_inc = beat_cnt + CNT_W'(1);
    assign hit_max      = (beat_cnt_inc == CNT_W'(MAX_BURST));

    // A stalled beat (valid but full) never ends the burst; a missing valid
    // always does, so an idle owner cannot starve the others.
    assign burst_end = (state == BURST) &&
                       (!g_valid || (accept && (g_last || hit_max)));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (burst_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs. Everything is derived from the state register, so an
    // asynchronous reset forces all outputs low in the same cycle.
    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        busy         = 1'b0;
        if (state == BURST) begin
            busy = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (GID_W'(i) == grant_id) begin
                    req_ready[i] = !fifo_full;
                end
            end
            if (accept) begin
                fifo_wr_en   = 1'b1;
                fifo_wr_data = g_data;
            end
        end
    end

    // Grant bookkeeping. last_winner resets to NUM_REQ-1 so the first search
    // starts at producer 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id    <= '0;
            last_winner <= GID_W'(NUM_REQ - 1);
            beat_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_id <= winner;
                        beat_cnt <= '0;
                    end
                end
                BURST: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt_inc;
                    end
                    if (burst_end) begin
                        last_winner <= grant_id;
                    end
                end
                default: begin
                    beat_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter

module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;
    localparam int GID_W     = 2;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full = 1'b0;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_wr_data;
    logic [GID_W-1:0]          grant_id;
    logic                      busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] idx [NUM_REQ];

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Beat k of producer p: tag byte p+1 on top, 0xA0/B0/C0/D0 + k at the bottom.
    function automatic logic [31:0] pdata(input int p, input int k);
        return 32'((p + 1) * 32'h1000_0000 + 32'hA0 + p * 32'h10 + k);
    endfunction

    // Producers advance to their next beat on each accepted handshake.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst_n) begin
                idx[i] <= 8'd0;
            end else if (req_valid[i] && req_ready[i]) begin
                idx[i] <= idx[i] + 8'd1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_prod
        assign req_data[gi*DATA_W +: DATA_W] = pdata(gi, int'(idx[gi]));
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already driven, check at the falling edge,
    // then move to just after the next rising edge.
    task automatic cyc(input string tag, input logic en, input logic [31:0] data,
                       input logic [3:0] rdy, input logic bsy, input logic [1:0] gid);
        @(negedge clk);
        check_val({tag, ".wr_en"},   64'(fifo_wr_en),   64'(en));
        check_val({tag, ".wr_data"}, 64'(fifo_wr_data), 64'(data));
        check_val({tag, ".ready"},   64'(req_ready),    64'(rdy));
        check_val({tag, ".busy"},    64'(busy),         64'(bsy));
        check_val({tag, ".gid"},     64'(grant_id),     64'(gid));
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, ".wr_en"},   64'(fifo_wr_en),   64'(0));
        check_val({tag, ".wr_data"}, 64'(fifo_wr_data), 64'(0));
        check_val({tag, ".ready"},   64'(req_ready),    64'(0));
        check_val({tag, ".busy"},    64'(busy),         64'(0));
        check_val({tag, ".gid"},     64'(grant_id),     64'(0));
    endtask

    task automatic do_reset(input string tag);
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        @(posedge clk);
        #1;
        check_zero(tag);
        rst_n = 1'b1;
    endtask

    initial begin
        // Two producers, MAX_BURST split, one idle cycle, rotation to 2.
        do_reset("rst");
        req_valid = 4'b0101;
        cyc("t1_c0", 1'b0, 32'h0, 4'b0000, 1'b0, 2'd0);
        for (int b = 0; b < 4; b++) begin
            cyc($sformatf("t1_p0b%0d", b), 1'b1, pdata(0, b), 4'b0001, 1'b1, 2'd0);
        end
        cyc("t1_c5", 1'b0, 32'h0, 4'b0000, 1'b0, 2'd0);
        cyc("t1_c6", 1'b1, pdata(2, 0), 4'b0100, 1'b1, 2'd2);
        cyc("t1_c7", 1'b1, pdata(2, 1), 4'b0100, 1'b1, 2'd2);
        req_valid = 4'b0000;
        cyc("t1_c8", 1'b0, 32'h0, 4'b0100, 1'b1, 2'd2);
        cyc("t1_c9", 1'b0, 32'h0, 4'b0000, 1'b0, 2'd2);

        // All four continuously valid: 0,1,2,3,0 with 4 beats each.
        do_reset("t2_rst");
        req_valid = 4'b1111;
        cyc("t2_c0", 1'b0, 32'h0, 4'b0000, 1'b0, 2'd0);
        for (int r = 0; r < 4; r++) begin
            for (int b = 0; b < 4; b++) begin
                cyc($sformatf("t2_g%0db%0d", r, b), 1'b1, pdata(r, b),
                    4'(1 << r), 1'b1, 2'(r));
            end
            cyc($sformatf("t2_idle%0d", r), 1'b0, 32'h0, 4'b0000, 1'b0, 2'(r));
        end
        cyc("t2_wrap", 1'b1, pdata(0, 4), 4'b0001, 1'b1, 2'd0);

        // Producer 1 two-beat packet, then next valid above 1 is 3.
        do_reset("t3_rst");
        req_valid = 4'b1010;
        cyc("t3_c0", 1'b0, 32'h0, 4'b0000, 1'b0, 2'd0);
        cyc("t3_b0", 1'b1, pdata(1, 0), 4'b0010, 1'b1, 2'd1);
        req_last = 4'b0010;
        cyc("t3_b1", 1'b1, pdata(1, 1), 4'b0010, 1'b1, 2'd1);
        req_last  = 4'b0000;
        req_valid = 4'b1001;
        cyc("t3_idle", 1'b0, 32'h0, 4'b0000, 1'b0, 2'd1);
        cyc("t3_g3", 1'b1, pdata(3, 0), 4'b1000, 1'b1, 2'd3);

        // FIFO full for three cycles after beat 1.
        do_reset("t4_rst");
        req_valid = 4'b0001;
        cyc("t4_c0", 1'b0, 32'h0, 4'b0000, 1'b0, 2'd0);
        cyc("t4_b0", 1'b1, pdata(0, 0), 4'b0001, 1'b1, 2'd0);
        fifo_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            cyc($sformatf("t4_stall%0d", s), 1'b0, 32'h0, 4'b0000, 1'b1, 2'd0);
        end
        fifo_full = 1'b0;
        for (int b = 1; b < 4; b++) begin
            cyc($sformatf("t4_b%0d", b), 1'b1, pdata(0, b), 4'b0001, 1'b1, 2'd0);
        end
        cyc("t4_idle", 1'b0, 32'h0, 4'b0000, 1'b0, 2'd0);

        // Granted producer drops valid after beat 2; producer 3 waits.
        do_reset("t5_rst");
        req_valid = 4'b1001;
        cyc("t5_c0", 1'b0, 32'h0, 4'b0000, 1'b0, 2'd0);
        cyc("t5_b0", 1'b1, pdata(0, 0), 4'b0001, 1'b1, 2'd0);
        cyc("t5_b1", 1'b1, pdata(0, 1), 4'b0001, 1'b1, 2'd0);
        req_valid = 4'b1000;
        cyc("t5_drop", 1'b0, 32'h0, 4'b0001, 1'b1, 2'd0);
        req_valid = 4'b1001;
        cyc("t5_idle", 1'b0, 32'h0, 4'b0000, 1'b0, 2'd0);
        cyc("t5_g3", 1'b1, pdata(3, 0), 4'b1000, 1'b1, 2'd3);

        // Reset pulsed during beat 3 of a burst.
        do_reset("t6_rst");
        req_valid = 4'b0001;
        cyc("t6_c0", 1'b0, 32'h0, 4'b0000, 1'b0, 2'd0);
        cyc("t6_b0", 1'b1, pdata(0, 0), 4'b0001, 1'b1, 2'd0);
        cyc("t6_b1", 1'b1, pdata(0, 1), 4'b0001, 1'b1, 2'd0);
        #1;
        check_val("t6_b2.wr_en", 64'(fifo_wr_en), 64'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("t6_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("t6_post_idle", 1'b0, 32'h0, 4'b0000, 1'b0, 2'd0);
        cyc("t6_post_b0", 1'b1, pdata(0, 0), 4'b0001, 1'b1, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the write port of the 32-bit × 256 single-clock FIFO among `NUM_REQ` producers. Each producer presents a valid/ready stream with a `last` marker. The arbiter locks onto one producer for a burst of up to `MAX_BURST` beats, then forwards accepted beats to the FIFO `wr_en`/`wr_data` and back-pressures on FIFO `full`. It sits directly in front of the FIFO write side, in the same clock domain.

## Interface
Parameters:
- `NUM_REQ`, 4, number of producers (2..8)
- `DATA_W`, 32, beat width; must match the FIFO data width
- `MAX_BURST`, 4, maximum beats per grant (1..15)

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  per-producer beat valid
- `req_data`  in  NUM_REQ*DATA_W  producer i occupies bits [i*DATA_W +: DATA_W]
- `req_last`  in  NUM_REQ  final beat of producer's packet
- `req_ready`  out  NUM_REQ  per-producer beat accepted this cycle (when valid)
- `fifo_full`  in  1  FIFO full flag
- `fifo_wr_en`  out  1  FIFO write strobe
- `fifo_wr_data`  out  DATA_W  FIFO write data
- `grant_id`  out  clog2(NUM_REQ)  current/last owner index
- `busy`  out  1  high while in BURST state

## Operation
- State machine with two states: IDLE and BURST. Registers: `state`, `grant_id`, `last_winner`, and `beat_cnt` (width clog2(MAX_BURST+1)).
- IDLE:
  - `req_ready` = 0 and `fifo_wr_en` = 0.
  - If any `req_valid` is high, select the first valid index searching from `last_winner+1` upward with wrap modulo NUM_REQ.
  - On the next edge: `grant_id` ← winner, `beat_cnt` ← 0, state → BURST.
- BURST, with g = `grant_id`:
  - `req_ready[g]` = !`fifo_full`; all other `req_ready` bits = 0.
  - A beat is accepted when `req_valid[g]` && !`fifo_full`.
  - Accepted beat: `fifo_wr_en` = 1 and `fifo_wr_data` = slice g of `req_data`, both combinational in the same cycle. `beat_cnt` increments on the edge.
  - Burst ends (state → IDLE, `last_winner` ← g) at the edge of a cycle where either:
    - an accepted beat has `req_last[g]` = 1, or
    - an accepted beat brings `beat_cnt`+1 to MAX_BURST, or
    - `req_valid[g]` = 0 (producer went idle; release so that others are not starved).
  - `fifo_full` = 1 with `req_valid[g]` = 1: the beat is stalled. Grant is held, `beat_cnt` is unchanged, and there is no timeout.
- `fifo_wr_data` = 0 whenever `fifo_wr_en` = 0.
- Non-granted producers' valid/data are ignored; no beat is ever dropped or duplicated.
- A packet longer than MAX_BURST is split across grants. Other producers may interleave between the splits, so FIFO contents are beat-interleaved at burst granularity.

## Timing
- Reset (asynchronous assert; release synchronous to `clk`):
  - state = IDLE, `grant_id` = 0, `last_winner` = NUM_REQ-1 (producer 0 wins first), `beat_cnt` = 0.
  - All outputs 0: `req_ready`, `fifo_wr_en`, `fifo_wr_data`, `busy`.
- Reset asserted mid-burst: outputs drop to 0 immediately. A beat in that cycle is not written.
- Latency:
  - `req_valid` rising in IDLE at cycle 0 → grant at edge 1 → first beat written in cycle 1.
  - Back-to-back beats within a burst: 1 per cycle.
- Burst switch overhead: exactly 1 IDLE cycle between bursts, so peak throughput with rotation is MAX_BURST/(MAX_BURST+1).
- `fifo_full` → `req_ready` is a combinational path with zero cycles of latency. The FIFO's registered `full` keeps this path short.
- Simultaneous events:
  - `req_last` and MAX_BURST reached in the same beat end the burst once, with a single `last_winner` update.
  - `fifo_full` deasserting in the same cycle as valid: the beat is accepted that cycle.

## Test plan
- Reset → all outputs 0. Producers 0 and 2 valid at cycle 0 → `grant_id`=0 at cycle 1 and `busy`=1; producer 0 beats 0xA0..0xA3 written in cycles 1–4; cycle 5 IDLE; producer 2 granted from cycle 6.
- All four producers continuously valid, `req_last`=0, MAX_BURST=4 → grants rotate 0,1,2,3,0. Each grant writes exactly 4 beats, and each burst is followed by one IDLE cycle.
- Producer 1 sends a 2-beat packet with `req_last` on beat 2 → exactly 2 writes, then IDLE. Next grant goes to the next valid index above 1.
- `fifo_full` held high for 3 cycles mid-burst after beat 1 → `fifo_wr_en`=0 and `req_ready[g]`=0 for those 3 cycles; grant held; beats 2–4 follow with data order intact.
- Granted producer drops `req_valid` for one cycle after beat 2 → arbiter returns to IDLE. Waiting producer 3 is granted at the following edge. The FIFO receives no spurious write.
- `rst_n` pulsed low during beat 3 of a burst → outputs 0 within the same cycle; after release, `grant_id`=0 and arbitration restarts at producer 0.
